// File: rtl/mem_copy_pkg.sv
// Shared state encoding and default sizes for the memory copy engine.
// The optional fill feature is enabled by defining MEM_COPY_FILL_EN (see mem_copy_engine).
package mem_copy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mc_state_e;

    localparam int MC_DEPTH     = 16;
    localparam int MC_ADDR_W    = 4;
    localparam int MC_DATA_W    = 8;
    localparam int MC_LEN_W     = 5;
    localparam int MC_SYNC_READ = 0;

endpackage

// File: rtl/mem_copy_rd_pipe.sv
// Delays the write-side enable/address so they line up with the memory's read data:
// pass-through for an asynchronous-read memory, one register stage for a registered-address one.
module mem_copy_rd_pipe
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W    = MC_ADDR_W,
    parameter int SYNC_READ = MC_SYNC_READ
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    generate
        if (SYNC_READ != 0) begin : g_stage
            always_ff @(posedge clock) begin
                if (!reset) begin
                    wr_en   <= 1'b0;
                    wr_addr <= '0;
                end else begin
                    wr_en   <= issue_en;
                    wr_addr <= issue_addr;
                end
            end
        end else begin : g_pass
            logic unused_pass;
            assign unused_pass = clock ^ reset;

            always_comb begin
                wr_en   = issue_en;
                wr_addr = issue_addr;
            end
        end
    endgenerate

endmodule

// File: rtl/mem_copy_engine.sv
// Copy initiator for one read lane and one write lane of a packed multi-port memory.
// Define MEM_COPY_FILL_EN to enable pattern-fill commands (cmd_fill / cmd_pattern).
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int DEPTH     = MC_DEPTH,
    parameter int ADDR_W    = MC_ADDR_W,
    parameter int DATA_W    = MC_DATA_W,
    parameter int LEN_W     = MC_LEN_W,
    parameter int SYNC_READ = MC_SYNC_READ
) (
    input  logic              clock,
    input  logic              reset,
    // Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready;
    // its fields are sampled only on that edge, and cmd_valid while busy is ignored.
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_fill,
    input  logic [DATA_W-1:0] cmd_pattern,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic              mem_wr_mask,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    output mc_state_e         dbg_state
);

    mc_state_e         state;
    logic [LEN_W-1:0]  remain_q;
    logic              iss_en_q;
    logic [ADDR_W-1:0] iss_addr_q;
    logic              fill_act;
    logic              fill_cmd;
    logic [DATA_W-1:0] fill_data;
    logic              pipe_in_en;
    logic              pipe_wr_en;
    logic [ADDR_W-1:0] pipe_wr_addr;

    assign dbg_state = state;

`ifdef MEM_COPY_FILL_EN
    logic              fill_q;
    logic [DATA_W-1:0] pattern_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            fill_q    <= 1'b0;
            pattern_q <= '0;
        end else if (cmd_valid && cmd_ready) begin
            fill_q    <= cmd_fill;
            pattern_q <= cmd_pattern;
        end
    end

    assign fill_cmd  = cmd_fill;
    assign fill_act  = fill_q;
    assign fill_data = pattern_q;
`else
    logic unused_fill;
    assign unused_fill = cmd_fill ^ (^cmd_pattern);
    assign fill_cmd    = 1'b0;
    assign fill_act    = 1'b0;
    assign fill_data   = '0;
`endif

    // Fill writes need no read data, so they bypass the alignment stage.
    assign pipe_in_en = iss_en_q & ~fill_act;

    mem_copy_rd_pipe #(
        .ADDR_W    (ADDR_W),
        .SYNC_READ (SYNC_READ)
    ) u_rd_pipe (
        .clock      (clock),
        .reset      (reset),
        .issue_en   (pipe_in_en),
        .issue_addr (iss_addr_q),
        .wr_en      (pipe_wr_en),
        .wr_addr    (pipe_wr_addr)
    );

    always_comb begin
        if (fill_act) begin
            mem_wr_en   = iss_en_q;
            mem_wr_addr = iss_addr_q;
            mem_wr_data = fill_data;
        end else begin
            mem_wr_en   = pipe_wr_en;
            mem_wr_addr = pipe_wr_addr;
            mem_wr_data = mem_rd_data;
        end
        if (!mem_wr_en) begin
            mem_wr_addr = '0;
            mem_wr_data = '0;
        end
        mem_wr_mask = mem_wr_en;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            words_done  <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            iss_en_q    <= 1'b0;
            iss_addr_q  <= '0;
            remain_q    <= '0;
        end else begin
            done <= 1'b0;
            if (mem_wr_en) begin
                words_done <= words_done + LEN_W'(1);
            end
            unique case (state)
                // DONE already shows cmd_ready, so a new command may start there.
                IDLE, DONE: begin
                    state <= IDLE;
                    if (cmd_valid && cmd_ready) begin
                        words_done <= '0;
                        if (cmd_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= RUN;
                            cmd_ready   <= 1'b0;
                            busy        <= 1'b1;
                            mem_rd_en   <= ~fill_cmd;
                            mem_rd_addr <= cmd_src;
                            iss_en_q    <= 1'b1;
                            iss_addr_q  <= cmd_dst;
                            remain_q    <= cmd_len;
                        end
                    end
                end
                RUN: begin
                    if (remain_q == LEN_W'(1)) begin
                        mem_rd_en <= 1'b0;
                        iss_en_q  <= 1'b0;
                        if (fill_act || SYNC_READ == 0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        remain_q    <= remain_q - LEN_W'(1);
                        mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
                        iss_addr_q  <= iss_addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state     <= DONE;
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: one instance per read style against a behavioural memory,
// checked against a sequential copy model. Define MEM_COPY_FILL_EN to also cover fill mode.
module tb_mem_copy_engine;
    import mem_copy_pkg::*;

    localparam int AW = 4, DW = 8, LW = 5, DEPTH = 16;
`ifdef MEM_COPY_FILL_EN
    localparam bit FILL_ON = 1'b1;
`else
    localparam bit FILL_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic              cmd_valid   [2];
    logic              cmd_ready   [2];
    logic [AW-1:0]     cmd_src     [2];
    logic [AW-1:0]     cmd_dst     [2];
    logic [LW-1:0]     cmd_len     [2];
    logic              cmd_fill    [2];
    logic [DW-1:0]     cmd_pattern [2];
    logic              mem_rd_en   [2];
    logic [AW-1:0]     mem_rd_addr [2];
    logic [DW-1:0]     mem_rd_data [2];
    logic              mem_wr_en   [2];
    logic              mem_wr_mask [2];
    logic [AW-1:0]     mem_wr_addr [2];
    logic [DW-1:0]     mem_wr_data [2];
    logic              busy        [2];
    logic              done        [2];
    logic [LW-1:0]     words_done  [2];
    mc_state_e         dbg_state   [2];

    logic [DW-1:0] mem [2][DEPTH];
    logic [AW-1:0] rd_addr_q [2];
    logic          load_req [2];
    logic [DW-1:0] load_img [DEPTH];

    // Instance 0 sees an asynchronous-read memory, instance 1 a registered-address one.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            mem_copy_engine #(
                .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .SYNC_READ(g)
            ) u_dut (
                .clock(clock), .reset(reset),
                .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
                .cmd_src(cmd_src[g]), .cmd_dst(cmd_dst[g]), .cmd_len(cmd_len[g]),
                .cmd_fill(cmd_fill[g]), .cmd_pattern(cmd_pattern[g]),
                .mem_rd_en(mem_rd_en[g]), .mem_rd_addr(mem_rd_addr[g]),
                .mem_rd_data(mem_rd_data[g]),
                .mem_wr_en(mem_wr_en[g]), .mem_wr_mask(mem_wr_mask[g]),
                .mem_wr_addr(mem_wr_addr[g]), .mem_wr_data(mem_wr_data[g]),
                .busy(busy[g]), .done(done[g]), .words_done(words_done[g]),
                .dbg_state(dbg_state[g])
            );
            if (g == 0) begin : g_async
                assign mem_rd_data[g] = mem[g][mem_rd_addr[g]];
            end else begin : g_sync
                assign mem_rd_data[g] = mem[g][rd_addr_q[g]];
            end
        end
    endgenerate

    always @(posedge clock) begin
        for (int s = 0; s < 2; s++) begin
            if (load_req[s]) begin
                for (int i = 0; i < DEPTH; i++) mem[s][i] <= load_img[i];
            end else if (mem_wr_en[s] && mem_wr_mask[s]) begin
                mem[s][mem_wr_addr[s]] <= mem_wr_data[s];
            end
            if (!reset) rd_addr_q[s] <= '0;
            else if (mem_rd_en[s]) rd_addr_q[s] <= mem_rd_addr[s];
        end
    end

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_rd_q[$];
    logic [DW-1:0] exp_wr_q[$];
    logic [DW-1:0] obs_data_q[$];
    logic [DW-1:0] obs_rd_q[$];
    logic [DW-1:0] obs_wr_q[$];
    logic [DW-1:0] exp_img [DEPTH];

    function automatic int diff_q(input logic [DW-1:0] a[$], input logic [DW-1:0] b[$]);
        int n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) n++;
        return n;
    endfunction

    function automatic int mem_diff(input int s);
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[s][i] !== exp_img[i]) n++;
        return n;
    endfunction

    function automatic int exp_done(input int s, input int len, input logic fill);
        if (len == 0) return 1;
        return len + 1 + ((FILL_ON && fill) ? 0 : s);
    endfunction

    function automatic int exp_first_wr(input int s, input int len, input logic fill);
        if (len == 0) return -1;
        return 1 + ((FILL_ON && fill) ? 0 : s);
    endfunction

    // Reference: copy word by word in ascending order on a snapshot of the memory.
    task automatic build_expect(input int s, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                                input int len, input logic fill, input logic [DW-1:0] pat);
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] d;
        exp_img = mem[s];
        exp_q.delete(); exp_rd_q.delete(); exp_wr_q.delete();
        for (int k = 0; k < len; k++) begin
            ra = src + AW'(k);
            wa = dst + AW'(k);
            if (FILL_ON && fill) d = pat;
            else begin
                d = exp_img[ra];
                exp_rd_q.push_back(DW'(ra));
            end
            exp_img[wa] = d;
            exp_wr_q.push_back(DW'(wa));
            exp_q.push_back(d);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic load_mem(input int s);
        @(negedge clock);
        load_req[s] = 1'b1;
        @(negedge clock);
        load_req[s] = 1'b0;
    endtask

    task automatic random_image();
        for (int i = 0; i < DEPTH; i++) load_img[i] = DW'($urandom_range(0, 255));
    endtask

    task automatic issue_cmd(input int s, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                             input logic [LW-1:0] len, input logic fill, input logic [DW-1:0] pat,
                             output logic was_ready);
        @(negedge clock);
        cmd_src[s] = src; cmd_dst[s] = dst; cmd_len[s] = len;
        cmd_fill[s] = fill; cmd_pattern[s] = pat; cmd_valid[s] = 1'b1;
        was_ready = cmd_ready[s];
        @(posedge clock);
        #1 cmd_valid[s] = 1'b0;
    endtask

    // Samples cycles 1.. after acceptance; optionally offers junk commands while busy.
    task automatic observe(input int s, input logic poke, output int done_cyc, output int first_wr,
                           output int mask_bad, output int ready_bad);
        obs_data_q.delete(); obs_rd_q.delete(); obs_wr_q.delete();
        done_cyc = -1; first_wr = -1; mask_bad = 0; ready_bad = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clock);
            if (mem_wr_mask[s] !== mem_wr_en[s]) mask_bad++;
            if (mem_rd_en[s]) obs_rd_q.push_back(DW'(mem_rd_addr[s]));
            if (mem_wr_en[s]) begin
                if (first_wr < 0) first_wr = c;
                obs_wr_q.push_back(DW'(mem_wr_addr[s]));
                obs_data_q.push_back(mem_wr_data[s]);
            end
            if (done[s]) begin
                done_cyc = c;
                cmd_valid[s] = 1'b0;
                break;
            end
            if (cmd_ready[s] !== 1'b0) ready_bad++;
            if (poke) begin
                cmd_valid[s] = 1'b1;
                cmd_src[s] = AW'($urandom_range(0, 15));
                cmd_dst[s] = AW'($urandom_range(0, 15));
                cmd_len[s] = LW'($urandom_range(1, 5));
            end
        end
        cmd_valid[s] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            checks++; if (cmd_ready[s] !== 1'b1) $display("FAIL reset_ready s=%0d got %b exp 1", s, cmd_ready[s]);
            else checks += 0;
            if (cmd_ready[s] !== 1'b1) errors++;
            checks++; if (busy[s] !== 1'b0) begin errors++; $display("FAIL reset_busy s=%0d got %b exp 0", s, busy[s]); end
            checks++; if (done[s] !== 1'b0) begin errors++; $display("FAIL reset_done s=%0d got %b exp 0", s, done[s]); end
            checks++; if (words_done[s] !== '0) begin errors++; $display("FAIL reset_words s=%0d got %0d exp 0", s, words_done[s]); end
            checks++; if (dbg_state[s] !== IDLE) begin errors++; $display("FAIL reset_state s=%0d got %0d exp %0d", s, dbg_state[s], IDLE); end
            checks++;
            if ({mem_rd_en[s], mem_rd_addr[s], mem_wr_en[s], mem_wr_mask[s], mem_wr_addr[s], mem_wr_data[s]} !== '0) begin
                errors++;
                $display("FAIL reset_mem_outputs s=%0d got rd_en=%b rd_addr=%0d wr_en=%b mask=%b wr_addr=%0d wr_data=%0h exp all 0",
                         s, mem_rd_en[s], mem_rd_addr[s], mem_wr_en[s], mem_wr_mask[s], mem_wr_addr[s], mem_wr_data[s]);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_basic_copy(input int s);
        logic r; int dc, fw, mb, rb;
        random_image();
        for (int i = 0; i < 4; i++) load_img[2 + i] = DW'(8'hA1 + i);
        load_mem(s);
        build_expect(s, 4'd2, 4'd10, 4, 1'b0, 8'h00);
        issue_cmd(s, 4'd2, 4'd10, 5'd4, 1'b0, 8'h00, r);
        @(negedge clock);
        checks++; if (busy[s] !== 1'b1) begin errors++; $display("FAIL basic_busy s=%0d got %b exp 1", s, busy[s]); end
        checks++; if (mem_rd_addr[s] !== 4'd2) begin errors++; $display("FAIL basic_first_rd s=%0d got %0d exp 2", s, mem_rd_addr[s]); end
        observe(s, 1'b0, dc, fw, mb, rb);
        dc += 1; fw = (fw < 0) ? fw : fw + 1;
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL basic_accept s=%0d got %b exp 1", s, r); end
        checks++; if (dc !== 5 + s) begin errors++; $display("FAIL basic_done_cycle s=%0d got %0d exp %0d", s, dc, 5 + s); end
        checks++; if (words_done[s] !== 5'd4) begin errors++; $display("FAIL basic_words s=%0d got %0d exp 4", s, words_done[s]); end
        checks++; if (mb !== 0 || rb !== 0) begin errors++; $display("FAIL basic_mask_ready s=%0d got %0d/%0d exp 0/0", s, mb, rb); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[s][10 + i] !== DW'(8'hA1 + i)) begin
                errors++; $display("FAIL basic_mem s=%0d addr=%0d got %0h exp %0h", s, 10 + i, mem[s][10 + i], 8'hA1 + i);
            end
        end
    endtask

    task automatic test_zero_len();
        logic r; int dc, fw, mb, rb;
        for (int s = 0; s < 2; s++) begin
            random_image(); load_mem(s);
            build_expect(s, 4'd5, 4'd6, 0, 1'b0, 8'h00);
            issue_cmd(s, 4'd5, 4'd6, 5'd0, 1'b0, 8'h00, r);
            observe(s, 1'b0, dc, fw, mb, rb);
            checks++; if (dc !== 1) begin errors++; $display("FAIL zero_done_cycle s=%0d got %0d exp 1", s, dc); end
            checks++; if (obs_rd_q.size() + obs_wr_q.size() !== 0) begin errors++; $display("FAIL zero_access s=%0d got %0d exp 0", s, obs_rd_q.size() + obs_wr_q.size()); end
            checks++; if (words_done[s] !== '0) begin errors++; $display("FAIL zero_words s=%0d got %0d exp 0", s, words_done[s]); end
            checks++; if (mem_diff(s) !== 0) begin errors++; $display("FAIL zero_mem s=%0d got %0d diffs exp 0", s, mem_diff(s)); end
        end
    endtask

    // Words 2 and 3 read addresses 0 and 1, which this copy has already rewritten.
    task automatic test_wrap_overlap();
        logic r; int dc, fw, mb, rb;
        logic [DW-1:0] want [4];
        want = '{8'd5, 8'd6, 8'd5, 8'd6};
        random_image();
        load_img[14] = 8'd5; load_img[15] = 8'd6; load_img[0] = 8'd7; load_img[1] = 8'd8;
        load_mem(0);
        build_expect(0, 4'd14, 4'd0, 4, 1'b0, 8'h00);
        issue_cmd(0, 4'd14, 4'd0, 5'd4, 1'b0, 8'h00, r);
        observe(0, 1'b0, dc, fw, mb, rb);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[0][i] !== want[i]) begin errors++; $display("FAIL wrap_mem addr=%0d got %0d exp %0d", i, mem[0][i], want[i]); end
        end
        checks++; if (diff_q(obs_rd_q, exp_rd_q) !== 0) begin errors++; $display("FAIL wrap_rd_addrs got %0d diffs exp 0", diff_q(obs_rd_q, exp_rd_q)); end
    endtask

    task automatic test_reset_abort();
        logic r; int bad;
        random_image(); load_mem(0);
        issue_cmd(0, 4'd0, 4'd8, 5'd8, 1'b0, 8'h00, r);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (mem_wr_en[0] !== 1'b0) begin errors++; $display("FAIL abort_wr_en got %b exp 0", mem_wr_en[0]); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy[0]); end
        checks++; if (cmd_ready[0] !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", cmd_ready[0]); end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        bad = 0;
        for (int i = 0; i < 2; i++) if (mem[0][8 + i] !== load_img[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL abort_written got %0d wrong exp 0", bad); end
        bad = 0;
        for (int i = 10; i < DEPTH; i++) if (mem[0][i] !== load_img[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL abort_untouched got %0d changed exp 0", bad); end
    endtask

    task automatic test_busy_ignore();
        logic r; int dc, fw, mb, rb;
        random_image(); load_mem(1);
        build_expect(1, 4'd3, 4'd7, 6, 1'b0, 8'h00);
        issue_cmd(1, 4'd3, 4'd7, 5'd6, 1'b0, 8'h00, r);
        observe(1, 1'b1, dc, fw, mb, rb);
        @(negedge clock);
        checks++; if (dc !== 8) begin errors++; $display("FAIL busy_done_cycle got %0d exp 8", dc); end
        checks++; if (rb !== 0) begin errors++; $display("FAIL busy_ready got %0d cycles exp 0", rb); end
        checks++; if (mem_diff(1) !== 0) begin errors++; $display("FAIL busy_mem got %0d diffs exp 0", mem_diff(1)); end
        checks++; if (words_done[1] !== 5'd6) begin errors++; $display("FAIL busy_words got %0d exp 6", words_done[1]); end
    endtask

    task automatic test_back_to_back();
        logic r; int dc, fw, mb, rb;
        random_image(); load_mem(0);
        build_expect(0, 4'd1, 4'd9, 3, 1'b0, 8'h00);
        issue_cmd(0, 4'd1, 4'd9, 5'd3, 1'b0, 8'h00, r);
        observe(0, 1'b0, dc, fw, mb, rb);
        checks++; if (mem_diff(0) !== 0) begin errors++; $display("FAIL b2b_first_mem got %0d diffs exp 0", mem_diff(0)); end
        build_expect(0, 4'd9, 4'd12, 5, 1'b0, 8'h00);
        cmd_src[0] = 4'd9; cmd_dst[0] = 4'd12; cmd_len[0] = 5'd5; cmd_fill[0] = 1'b0; cmd_valid[0] = 1'b1;
        checks++; if (cmd_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done got %b exp 1", cmd_ready[0]); end
        @(posedge clock);
        #1 cmd_valid[0] = 1'b0;
        observe(0, 1'b0, dc, fw, mb, rb);
        checks++; if (dc !== 6) begin errors++; $display("FAIL b2b_done_cycle got %0d exp 6", dc); end
        checks++; if (mem_diff(0) !== 0) begin errors++; $display("FAIL b2b_second_mem got %0d diffs exp 0", mem_diff(0)); end
    endtask

    task automatic test_random();
        logic r, fill; int dc, fw, mb, rb, s, len;
        logic [AW-1:0] src, dst;
        logic [DW-1:0] pat;
        for (int n = 0; n < 24; n++) begin
            s = $urandom_range(0, 1);
            len = $urandom_range(0, 20);
            src = AW'($urandom_range(0, 15));
            dst = AW'($urandom_range(0, 15));
            fill = ($urandom_range(0, 3) == 0);
            pat = DW'($urandom_range(0, 255));
            random_image(); load_mem(s);
            build_expect(s, src, dst, len, fill, pat);
            issue_cmd(s, src, dst, LW'(len), fill, pat, r);
            observe(s, 1'b0, dc, fw, mb, rb);
            checks++; if (dc !== exp_done(s, len, fill)) begin errors++; $display("FAIL rand_done n=%0d s=%0d len=%0d got %0d exp %0d", n, s, len, dc, exp_done(s, len, fill)); end
            checks++; if (fw !== exp_first_wr(s, len, fill)) begin errors++; $display("FAIL rand_first_wr n=%0d got %0d exp %0d", n, fw, exp_first_wr(s, len, fill)); end
            checks++; if (diff_q(obs_rd_q, exp_rd_q) !== 0) begin errors++; $display("FAIL rand_rd_addrs n=%0d got %0d diffs exp 0", n, diff_q(obs_rd_q, exp_rd_q)); end
            checks++; if (diff_q(obs_wr_q, exp_wr_q) !== 0) begin errors++; $display("FAIL rand_wr_addrs n=%0d got %0d diffs exp 0", n, diff_q(obs_wr_q, exp_wr_q)); end
            checks++; if (diff_q(obs_data_q, exp_q) !== 0) begin errors++; $display("FAIL rand_wr_data n=%0d got %0d diffs exp 0", n, diff_q(obs_data_q, exp_q)); end
            checks++; if (mb !== 0) begin errors++; $display("FAIL rand_mask n=%0d got %0d bad cycles exp 0", n, mb); end
            checks++; if (words_done[s] !== LW'(len)) begin errors++; $display("FAIL rand_words n=%0d got %0d exp %0d", n, words_done[s], len); end
            @(negedge clock);
            checks++; if (mem_diff(s) !== 0) begin errors++; $display("FAIL rand_mem n=%0d got %0d diffs exp 0", n, mem_diff(s)); end
            checks++; if (done[s] !== 1'b0) begin errors++; $display("FAIL rand_done_pulse n=%0d got %b exp 0", n, done[s]); end
        end
    endtask

`ifdef MEM_COPY_FILL_EN
    task automatic test_fill();
        logic r; int dc, fw, mb, rb;
        for (int s = 0; s < 2; s++) begin
            random_image(); load_mem(s);
            issue_cmd(s, 4'd0, 4'd3, 5'd3, 1'b1, 8'hA5, r);
            observe(s, 1'b0, dc, fw, mb, rb);
            @(negedge clock);
            checks++; if (dc !== 4) begin errors++; $display("FAIL fill_done_cycle s=%0d got %0d exp 4", s, dc); end
            checks++; if (obs_rd_q.size() !== 0) begin errors++; $display("FAIL fill_reads s=%0d got %0d exp 0", s, obs_rd_q.size()); end
            for (int i = 3; i < 6; i++) begin
                checks++; if (mem[s][i] !== 8'hA5) begin errors++; $display("FAIL fill_mem s=%0d addr=%0d got %0h exp a5", s, i, mem[s][i]); end
            end
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            cmd_valid[s] = 1'b0; cmd_src[s] = '0; cmd_dst[s] = '0; cmd_len[s] = '0;
            cmd_fill[s] = 1'b0; cmd_pattern[s] = '0; load_req[s] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) load_img[i] = '0;
        test_reset();
        test_basic_copy(0);
        test_basic_copy(1);
        test_zero_len();
        test_wrap_overlap();
        test_reset_abort();
        test_busy_ignore();
        test_back_to_back();
`ifdef MEM_COPY_FILL_EN
        test_fill();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
